tdm_scheduler: RTL

TDM_SCHEDULER -- requirements
Module: tdm_scheduler

---
 rtl/tdm_pkg.sv | 27 ++
 rtl/tdm_scheduler_rr_pick4.sv | 32 +++
 rtl/tdm_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// ----------------------------------------------------------------------------
// tdm_pkg : shared state encoding and channel defaults for tdm_scheduler. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tdm_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOT  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  function automatic logic [7:0] def_len(input logic [1:0] ch);
    case (ch)
      2'd0:    return 8'd143;
      2'd1:    return 8'd110;
      2'd2:    return 8'd77;
      default: return 8'd44;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_scheduler_rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4 : first set bit of a 4-bit mask, searching circularly from start_i. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick4
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [1:0]        start_i,
  output logic [1:0]        idx_o,
  output logic              found_o
);

  logic [1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = start_i;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = start_i + 2'(i);
      if (!found_o && mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdm_scheduler.sv
// ----------------------------------------------------------------------------
// tdm_scheduler : 4-channel TDM slot scheduler with guard gaps and symbol tick. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tdm_scheduler
  import tdm_pkg::*;
#(
  parameter int GUARD   = 2,
  parameter int SYM_LEN = 13
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [7:0]        cfg_len,
  output logic [1:0]        slot_sel,
  output logic              slot_valid,
  output logic              slot_start,
  output logic              frame_start,
  output logic [7:0]        rom_addr,
  output logic              sym_tick
);

  state_t      state_q, state_d;
  logic [7:0]  len_q [NUM_CH];
  logic [7:0]  cur_len_q, cur_len_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [3:0]  sym_cnt_q, sym_cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        sstart_q, sstart_d;
  logic        fstart_q, fstart_d;
  logic [7:0]  addr_q, addr_d;
  logic        tick_q, tick_d;
  logic        arm_q;
  logic        sel_now;

  logic [NUM_CH-1:0] elig;
  logic [1:0]        pick_idx;
  logic              pick_found;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_en[i] && (len_q[i] != 8'd0);
    end
  end

  rr_pick4 u_pick (
    .mask_i  (elig),
    .start_i (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // A write that coincides with a selection is seen by the following one only.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        len_q[i] <= def_len(2'(i));
      end
    end else if (cfg_we) begin
      len_q[cfg_sel] <= cfg_len;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gcnt_d    = gcnt_q;
    cur_len_d = cur_len_q;
    sel_d     = sel_q;
    valid_d   = 1'b0;
    sstart_d  = 1'b0;
    fstart_d  = 1'b0;
    addr_d    = '0;
    sym_cnt_d = '0;
    tick_d    = 1'b0;
    sel_now   = 1'b0;

    case (state_q)
      ST_IDLE: sel_now = run && arm_q;
      ST_SLOT: begin
        if (addr_q == cur_len_q - 8'd1) begin
          if (GUARD == 0) begin
            sel_now = 1'b1;
          end else begin
            state_d = ST_GUARD;
            gcnt_d  = '0;
          end
        end else begin
          valid_d = 1'b1;
          addr_d  = addr_q + 8'd1;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == 4'(GUARD - 1)) begin
          sel_now = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sel_now) begin
      if (pick_found) begin
        state_d   = ST_SLOT;
        sel_d     = pick_idx;
        cur_len_d = len_q[pick_idx];
        ptr_d     = pick_idx + 2'd1;
        valid_d   = 1'b1;
        sstart_d  = 1'b1;
        fstart_d  = (state_q == ST_IDLE) || (pick_idx <= sel_q);
      end else begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    end

    // Symbol counter restarts at 0 on the first active cycle after IDLE.
    if ((state_d != ST_IDLE) && (state_q != ST_IDLE)) begin
      sym_cnt_d = (sym_cnt_q == 4'(SYM_LEN - 1)) ? 4'd0 : sym_cnt_q + 4'd1;
    end
    tick_d = (state_d != ST_IDLE) && (sym_cnt_d == 4'(SYM_LEN - 1));

    if (!run) begin
      state_d   = ST_IDLE;
      ptr_d     = '0;
      gcnt_d    = '0;
      sel_d     = '0;
      valid_d   = 1'b0;
      sstart_d  = 1'b0;
      fstart_d  = 1'b0;
      addr_d    = '0;
      sym_cnt_d = '0;
      tick_d    = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_len_q <= '0;
      ptr_q     <= '0;
      gcnt_q    <= '0;
      sym_cnt_q <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      sstart_q  <= 1'b0;
      fstart_q  <= 1'b0;
      addr_q    <= '0;
      tick_q    <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_len_q <= cur_len_d;
      ptr_q     <= ptr_d;
      gcnt_q    <= gcnt_d;
      sym_cnt_q <= sym_cnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      sstart_q  <= sstart_d;
      fstart_q  <= fstart_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      arm_q     <= 1'b1;
    end
  end

  assign slot_sel    = sel_q;
  assign slot_valid  = valid_q;
  assign slot_start  = sstart_q;
  assign frame_start = fstart_q;
  assign rom_addr    = addr_q;
  assign sym_tick    = tick_q;

endmodule

`default_nettype wire
